// File: rtl/gpu_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, operation kinds and an index-width helper.
package gpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  // A single-port arbiter still needs a 1-bit index to keep every vector non-empty.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the per-core request ports and the single external memory channel.
interface data_mem_arbiter_if #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [NUM_CORES-1:0]           core_read_valid;
  logic [NUM_CORES*ADDR_BITS-1:0] core_read_address;
  logic [NUM_CORES-1:0]           core_read_ready;
  logic [NUM_CORES*DATA_BITS-1:0] core_read_data;
  logic [NUM_CORES-1:0]           core_write_valid;
  logic [NUM_CORES*ADDR_BITS-1:0] core_write_address;
  logic [NUM_CORES*DATA_BITS-1:0] core_write_data;
  logic [NUM_CORES-1:0]           core_write_ready;
  logic                           mem_read_valid;
  logic [ADDR_BITS-1:0]           mem_read_address;
  logic                           mem_read_ready;
  logic [DATA_BITS-1:0]           mem_read_data;
  logic                           mem_write_valid;
  logic [ADDR_BITS-1:0]           mem_write_address;
  logic [DATA_BITS-1:0]           mem_write_data;
  logic                           mem_write_ready;

  modport slave (
    input  core_read_valid, core_read_address, core_write_valid, core_write_address,
           core_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    output core_read_ready, core_read_data, core_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );

  modport master (
    output core_read_valid, core_read_address, core_write_valid, core_write_address,
           core_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    input  core_read_ready, core_read_data, core_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping modulo N.
module rr_picker
  import gpu_mem_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_bits(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_grant_valid,
  output logic [IW-1:0] o_grant_idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scanning from the farthest offset down lets the nearest requester overwrite the result.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[wrap_add(i_ptr, k)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = wrap_add(i_ptr, k);
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one external data-memory channel among NUM_CORES cache ports.
module data_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_arbiter_if.slave bus
);

  localparam int IW = idx_bits(NUM_CORES);

  arb_state_t                     r_state, w_next_state;
  op_t                            r_op;
  logic [IW-1:0]                  r_grant_idx, r_rr_ptr, w_grant_idx;
  logic                           w_grant_valid, w_sel_rvalid, w_held_valid;
  logic [NUM_CORES-1:0]           w_req, w_core_rready, w_core_wready;
  logic [ADDR_BITS-1:0]           r_addr, w_sel_raddr, w_sel_waddr;
  logic [DATA_BITS-1:0]           r_wdata, w_sel_wdata;
  logic [NUM_CORES*DATA_BITS-1:0] r_core_rdata;
  logic                           w_mem_rvalid, w_mem_wvalid;

  assign w_req = bus.core_read_valid | bus.core_write_valid;

  rr_picker #(.N(NUM_CORES), .IW(IW)) u_picker (
    .i_req         (w_req),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_sel_rvalid = 1'b0;
    w_sel_raddr  = '0;
    w_sel_waddr  = '0;
    w_sel_wdata  = '0;
    w_held_valid = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_grant_idx == IW'(i)) begin
        w_sel_rvalid = bus.core_read_valid[i];
        w_sel_raddr  = bus.core_read_address[i*ADDR_BITS +: ADDR_BITS];
        w_sel_waddr  = bus.core_write_address[i*ADDR_BITS +: ADDR_BITS];
        w_sel_wdata  = bus.core_write_data[i*DATA_BITS +: DATA_BITS];
      end
      if (r_grant_idx == IW'(i))
        w_held_valid = (r_op == OP_READ) ? bus.core_read_valid[i] : bus.core_write_valid[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // A core asking for both read and write gets the read first; the write waits for a later grant.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       if (w_grant_valid) w_next_state = w_sel_rvalid ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:  if (bus.mem_read_ready) w_next_state = RELAY;
      WRITE_WAIT: if (bus.mem_write_ready) w_next_state = RELAY;
      RELAY:      if (!w_held_valid) w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op         <= OP_READ;
      r_grant_idx  <= '0;
      r_rr_ptr     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_grant_valid) begin
        r_grant_idx <= w_grant_idx;
        r_op        <= w_sel_rvalid ? OP_READ : OP_WRITE;
        r_addr      <= w_sel_rvalid ? w_sel_raddr : w_sel_waddr;
        r_wdata     <= w_sel_wdata;
      end
      if (r_state == RELAY && !w_held_valid)
        r_rr_ptr <= (r_grant_idx == IW'(NUM_CORES - 1)) ? '0 : r_grant_idx + 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (r_state == READ_WAIT && bus.mem_read_ready && r_grant_idx == IW'(i))
          r_core_rdata[i*DATA_BITS +: DATA_BITS] <= bus.mem_read_data;
      end
    end
  end

  always_comb begin
    w_mem_rvalid  = (r_state == READ_WAIT);
    w_mem_wvalid  = (r_state == WRITE_WAIT);
    w_core_rready = '0;
    w_core_wready = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (r_state == RELAY && r_grant_idx == IW'(i)) begin
        if (r_op == OP_READ) w_core_rready[i] = 1'b1;
        else                 w_core_wready[i] = 1'b1;
      end
    end
  end

  assign bus.mem_read_valid    = w_mem_rvalid;
  assign bus.mem_write_valid   = w_mem_wvalid;
  assign bus.mem_read_address  = r_addr;
  assign bus.mem_write_address = r_addr;
  assign bus.mem_write_data    = r_wdata;
  assign bus.core_read_ready   = w_core_rready;
  assign bus.core_write_ready  = w_core_wready;
  assign bus.core_read_data    = r_core_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with two cores and a hand-driven memory side.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic       ec;
  logic [7:0] ea, ed;

  data_mem_arbiter_if #(.NUM_CORES(2), .ADDR_BITS(8), .DATA_BITS(8)) bus ();

  data_mem_arbiter #(.NUM_CORES(2), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_valid(input string tag, input bit is_write);
    int n;
    n = 0;
    @(negedge clk);
    while (((is_write ? bus.mem_write_valid : bus.mem_read_valid) !== 1'b1) && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(is_write ? bus.mem_write_valid : bus.mem_read_valid), 32'd1);
  endtask

  task automatic read_reply(input logic [7:0] d);
    bus.mem_read_data  = d;
    bus.mem_read_ready = 1'b1;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
  endtask

  task automatic write_reply();
    bus.mem_write_ready = 1'b1;
    @(negedge clk);
    bus.mem_write_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset                  = 1'b0;
    bus.core_read_valid    = 2'b11;
    bus.core_read_address  = {8'h44, 8'h10};
    bus.core_write_valid   = 2'b00;
    bus.core_write_address = '0;
    bus.core_write_data    = '0;
    bus.mem_read_ready     = 1'b0;
    bus.mem_read_data      = '0;
    bus.mem_write_ready    = 1'b0;

    // Reset held while both cores request.
    repeat (3) @(negedge clk);
    check("rst_mem_rvalid", 32'(bus.mem_read_valid), 32'd0);
    check("rst_mem_wvalid", 32'(bus.mem_write_valid), 32'd0);
    check("rst_core_rready", 32'(bus.core_read_ready), 32'd0);
    check("rst_core_wready", 32'(bus.core_write_ready), 32'd0);
    check("rst_core_rdata", 32'(bus.core_read_data), 32'd0);
    check("rst_mem_raddr", 32'(bus.mem_read_address), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_write_data), 32'd0);

    // Release: core 0 wins first, memory answers on the third valid cycle.
    reset = 1'b1;
    @(negedge clk);
    check("t1_rvalid_rise", 32'(bus.mem_read_valid), 32'd1);
    check("t1_raddr_core0", 32'(bus.mem_read_address), 32'h10);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t2_rvalid_hold", 32'(bus.mem_read_valid), 32'd1);
      check("t2_raddr_hold", 32'(bus.mem_read_address), 32'h10);
      check("t2_no_early_ready", 32'(bus.core_read_ready), 32'd0);
    end
    read_reply(8'hA5);
    check("t2_rready", 32'(bus.core_read_ready), 32'b01);
    check("t2_rdata", 32'(bus.core_read_data), 32'h00A5);
    check("t2_rvalid_drop", 32'(bus.mem_read_valid), 32'd0);
    bus.core_read_valid = 2'b10;
    @(negedge clk);
    check("t2_rready_drop", 32'(bus.core_read_ready), 32'd0);
    check("t2_idle_no_rvalid", 32'(bus.mem_read_valid), 32'd0);
    @(negedge clk);
    check("t2_core1_rvalid", 32'(bus.mem_read_valid), 32'd1);
    check("t2_core1_raddr", 32'(bus.mem_read_address), 32'h44);
    read_reply(8'h3C);
    check("t2_core1_rready", 32'(bus.core_read_ready), 32'b10);
    check("t2_core1_rdata", 32'(bus.core_read_data), 32'h3CA5);
    bus.core_read_valid = 2'b00;
    @(negedge clk);
    check("t2_core1_rready_drop", 32'(bus.core_read_ready), 32'd0);

    // Both cores keep writing: grants alternate 0,1,0,1.
    bus.core_write_address = {8'h30, 8'h20};
    bus.core_write_data    = {8'h22, 8'h11};
    bus.core_write_valid   = 2'b11;
    for (int t = 0; t < 4; t++) begin
      ec = (t % 2 == 1);
      ea = ec ? 8'h30 : 8'h20;
      ed = ec ? 8'h22 : 8'h11;
      wait_valid("t3_wvalid", 1'b1);
      check("t3_waddr", 32'(bus.mem_write_address), 32'(ea));
      check("t3_wdata", 32'(bus.mem_write_data), 32'(ed));
      check("t3_no_rvalid", 32'(bus.mem_read_valid), 32'd0);
      write_reply();
      check("t3_wready", 32'(bus.core_write_ready), ec ? 32'b10 : 32'b01);
      check("t3_wvalid_drop", 32'(bus.mem_write_valid), 32'd0);
      bus.core_write_valid[ec] = 1'b0;
      @(negedge clk);
      check("t3_wready_drop", 32'(bus.core_write_ready), 32'd0);
      if (t < 3) bus.core_write_valid[ec] = 1'b1;
      else       bus.core_write_valid = 2'b00;
    end

    // Core 1 reads and writes together: read first, then write.
    bus.core_read_address  = {8'h05, 8'h10};
    bus.core_write_address = {8'h06, 8'h20};
    bus.core_write_data    = {8'h77, 8'h11};
    bus.core_read_valid    = 2'b10;
    bus.core_write_valid   = 2'b10;
    wait_valid("t4_rvalid", 1'b0);
    check("t4_no_wvalid_during_read", 32'(bus.mem_write_valid), 32'd0);
    check("t4_raddr", 32'(bus.mem_read_address), 32'h05);
    read_reply(8'h99);
    check("t4_rready", 32'(bus.core_read_ready), 32'b10);
    check("t4_wready_not_yet", 32'(bus.core_write_ready), 32'd0);
    check("t4_rdata", 32'(bus.core_read_data), 32'h99A5);
    bus.core_read_valid = 2'b00;
    @(negedge clk);
    check("t4_rready_drop", 32'(bus.core_read_ready), 32'd0);
    wait_valid("t4_wvalid", 1'b1);
    check("t4_no_rvalid_during_write", 32'(bus.mem_read_valid), 32'd0);
    check("t4_waddr", 32'(bus.mem_write_address), 32'h06);
    check("t4_wdata", 32'(bus.mem_write_data), 32'h77);
    write_reply();
    check("t4_wready", 32'(bus.core_write_ready), 32'b10);
    bus.core_write_valid = 2'b00;
    @(negedge clk);
    check("t4_wready_drop", 32'(bus.core_write_ready), 32'd0);

    // Reset in READ_WAIT, then a late memory ready that must be ignored.
    bus.core_read_address = {8'h44, 8'h10};
    bus.core_read_valid   = 2'b01;
    wait_valid("t5_rvalid", 1'b0);
    reset               = 1'b0;
    bus.core_read_valid = 2'b00;
    #1;
    check("t5_rvalid_async_clear", 32'(bus.mem_read_valid), 32'd0);
    @(negedge clk);
    check("t5_rdata_cleared", 32'(bus.core_read_data), 32'd0);
    reset              = 1'b1;
    bus.mem_read_data  = 8'hEE;
    bus.mem_read_ready = 1'b1;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
    check("t5_late_ready_rready", 32'(bus.core_read_ready), 32'd0);
    check("t5_late_ready_wready", 32'(bus.core_write_ready), 32'd0);
    check("t5_late_ready_rdata", 32'(bus.core_read_data), 32'd0);
    @(negedge clk);
    check("t5_idle_rvalid", 32'(bus.mem_read_valid), 32'd0);
    check("t5_idle_wvalid", 32'(bus.mem_write_valid), 32'd0);

    // Core 0 lingers on valid for 4 cycles; core 1 waits until IDLE is re-entered.
    bus.core_read_valid = 2'b11;
    wait_valid("t6_rvalid_core0", 1'b0);
    check("t6_raddr_core0", 32'(bus.mem_read_address), 32'h10);
    read_reply(8'h5A);
    for (int c = 0; c < 4; c++) begin
      check("t6_rready_held", 32'(bus.core_read_ready), 32'b01);
      check("t6_core1_waits", 32'(bus.mem_read_valid), 32'd0);
      if (c == 3) bus.core_read_valid = 2'b10;
      @(negedge clk);
    end
    check("t6_rready_drop", 32'(bus.core_read_ready), 32'd0);
    check("t6_idle_no_rvalid", 32'(bus.mem_read_valid), 32'd0);
    @(negedge clk);
    check("t6_core1_rvalid", 32'(bus.mem_read_valid), 32'd1);
    check("t6_core1_raddr", 32'(bus.mem_read_address), 32'h44);
    read_reply(8'h6B);
    check("t6_core1_rready", 32'(bus.core_read_ready), 32'b10);
    check("t6_core1_rdata", 32'(bus.core_read_data), 32'h6B5A);
    bus.core_read_valid = 2'b00;
    @(negedge clk);
    check("t6_core1_rready_drop", 32'(bus.core_read_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
